// File: rtl/bitwise_unit_mc.sv
//============================================================================
// Module   : bitwise_unit_mc
// Purpose  : Multi-cycle WIDTH-bit bitwise logic unit. Operands are latched
//            at start and processed SLICE bits per clock through one shared
//            SLICE-bit gate array, under a start/busy/done handshake.
// Ports    : clk    - rising-edge clock
//            reset  - asynchronous active-high reset
//            start  - request, sampled only while busy = 0
//            op     - operation select (latched with start)
//                       000 NOT a   001 AND   010 OR    011 XOR
//                       100 NOR     101 NAND  110 XNOR  111 PASS a
//            a, b   - operands (latched with start)
//            busy   - high while slices are being processed
//            done   - one-cycle pulse when result is complete
//            result - registered result, held until the next accepted start
//            zero   - result == 0 flag, valid from done
//                     (only with BITWISE_ZERO_FLAG_EN)
// Macro    : BITWISE_ZERO_FLAG_EN - adds the registered zero flag output
// Revision : 1.0 - initial release
//============================================================================
`default_nettype none

module bitwise_unit_mc #(
    parameter int WIDTH = 32,
    parameter int SLICE = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result
`ifdef BITWISE_ZERO_FLAG_EN
    ,
    output logic             zero
`endif
);

    localparam int c_n     = WIDTH / SLICE;
    // One extra count so the counter can sit at N after the last slice
    // without overflowing.
    localparam int c_idx_w = $clog2(c_n + 1);

    localparam logic [c_idx_w-1:0] c_last = c_idx_w'(c_n - 1);
    localparam logic [c_idx_w-1:0] c_one  = c_idx_w'(1);

    localparam logic [1:0] c_st_idle = 2'd0;
    localparam logic [1:0] c_st_run  = 2'd1;
    localparam logic [1:0] c_st_done = 2'd2;

    logic [1:0]         r_state;
    logic [1:0]         w_state_next;
    logic               w_accept;
    logic               w_last;

    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic [2:0]         r_op;
    logic [c_idx_w-1:0] r_idx;
    logic [WIDTH-1:0]   r_result;

    logic [SLICE-1:0]   w_a_slice;
    logic [SLICE-1:0]   w_b_slice;
    logic [SLICE-1:0]   w_slice;
    logic [WIDTH-1:0]   w_result_next;

    //------------------------------------------------------------------------
    // Next-state logic
    //------------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        w_last       = (r_idx == c_last);
        case (r_state)
            c_st_idle: begin
                if (start) begin
                    w_accept     = 1'b1;
                    w_state_next = c_st_run;
                end
            end
            c_st_run: begin
                if (w_last) begin
                    w_state_next = c_st_done;
                end
            end
            c_st_done: begin
                // A start in the done cycle chains straight into RUN.
                if (start) begin
                    w_accept     = 1'b1;
                    w_state_next = c_st_run;
                end else begin
                    w_state_next = c_st_idle;
                end
            end
            default: begin
                w_state_next = c_st_idle;
            end
        endcase
    end

    //------------------------------------------------------------------------
    // Shared slice gate array
    //------------------------------------------------------------------------
    always_comb begin
        w_a_slice = r_a[r_idx*SLICE +: SLICE];
        w_b_slice = r_b[r_idx*SLICE +: SLICE];
        case (r_op)
            3'b000:  w_slice = ~w_a_slice;
            3'b001:  w_slice = w_a_slice & w_b_slice;
            3'b010:  w_slice = w_a_slice | w_b_slice;
            3'b011:  w_slice = w_a_slice ^ w_b_slice;
            3'b100:  w_slice = ~(w_a_slice | w_b_slice);
            3'b101:  w_slice = ~(w_a_slice & w_b_slice);
            3'b110:  w_slice = ~(w_a_slice ^ w_b_slice);
            default: w_slice = w_a_slice;
        endcase
    end

    // Result with the current slice merged in; on the final RUN cycle this is
    // the complete result, which also feeds the zero flag.
    always_comb begin
        w_result_next                         = r_result;
        w_result_next[r_idx*SLICE +: SLICE]   = w_slice;
    end

    //------------------------------------------------------------------------
    // State and datapath registers
    //------------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= c_st_idle;
            r_a      <= '0;
            r_b      <= '0;
            r_op     <= '0;
            r_idx    <= '0;
            r_result <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_accept) begin
                r_a      <= a;
                r_b      <= b;
                r_op     <= op;
                r_idx    <= '0;
                r_result <= '0;
            end else if (r_state == c_st_run) begin
                r_result <= w_result_next;
                r_idx    <= r_idx + c_one;
            end
        end
    end

`ifdef BITWISE_ZERO_FLAG_EN
    logic r_zero;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_zero <= 1'b0;
        end else if (w_accept) begin
            r_zero <= 1'b0;
        end else if ((r_state == c_st_run) && w_last) begin
            r_zero <= (w_result_next == '0);
        end
    end

    assign zero = r_zero;
`endif

    // Status flags are pure decodes of the state register.
    assign busy   = (r_state == c_st_run);
    assign done   = (r_state == c_st_done);
    assign result = r_result;

endmodule

`default_nettype wire

// File: tb/tb_bitwise_unit_mc.sv
//============================================================================
// Module   : tb_bitwise_unit_mc
// Purpose  : Self-checking bench for bitwise_unit_mc (WIDTH=32, SLICE=8).
//            Directed vectors plus randomized operations compared against a
//            whole-word behavioural model.
// Revision : 1.0 - initial release
//============================================================================
`default_nettype none

module tb_bitwise_unit_mc;

    localparam int W = 32;
    localparam int S = 8;
    localparam int N = W / S;

    logic         clk;
    logic         reset;
    logic         start;
    logic [2:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic [W-1:0] result;
`ifdef BITWISE_ZERO_FLAG_EN
    logic         zero;
`endif

    int n_checks = 0;
    int n_errors = 0;

    bitwise_unit_mc #(
        .WIDTH (W),
        .SLICE (S)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .op     (op),
        .a      (a),
        .b      (b),
        .busy   (busy),
        .done   (done),
        .result (result)
`ifdef BITWISE_ZERO_FLAG_EN
        ,
        .zero   (zero)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Whole-word reference: the slicing is an implementation detail.
    function automatic logic [W-1:0] ref_op(input logic [2:0] o, input logic [W-1:0] x,
                                             input logic [W-1:0] y);
        case (o)
            3'd0:    return ~x;
            3'd1:    return x & y;
            3'd2:    return x | y;
            3'd3:    return x ^ y;
            3'd4:    return ~(x | y);
            3'd5:    return ~(x & y);
            3'd6:    return ~(x ^ y);
            default: return x;
        endcase
    endfunction

    // Called right after the start edge. mode 0: drop start and scramble the
    // inputs; mode 1: re-pulse start with new operands on the next two edges;
    // mode 2: keep start high and present the next operation's operands.
    task automatic expect_op(input string tag, input logic [W-1:0] exp_res, input int mode,
                             input logic [2:0] nop, input logic [W-1:0] na,
                             input logic [W-1:0] nb);
        int cyc;
        int busy_cyc;
        cyc      = 0;
        busy_cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
            if (done !== 1'b1 && busy === 1'b1) busy_cyc++;
            case (mode)
                0: if (cyc == 1) begin
                    start = 1'b0;
                    op    = 3'($urandom);
                    a     = $urandom;
                    b     = $urandom;
                end
                1: if (cyc <= 2) begin
                    start = 1'b1;
                    op    = 3'($urandom);
                    a     = $urandom;
                    b     = $urandom;
                end else begin
                    start = 1'b0;
                end
                default: if (cyc == 1) begin
                    op = nop;
                    a  = na;
                    b  = nb;
                end
            endcase
        end while (done !== 1'b1 && cyc < 20);
        check({tag, " latency"}, 64'(cyc), 64'(N + 1));
        check({tag, " busy cycles"}, 64'(busy_cyc), 64'(N));
        check({tag, " result"}, 64'(result), 64'(exp_res));
`ifdef BITWISE_ZERO_FLAG_EN
        check({tag, " zero"}, 64'(zero), 64'(exp_res == '0));
`endif
        if (mode != 2) begin
            @(negedge clk);
            check({tag, " single done"}, 64'(done), 64'(0));
        end
    endtask

    task automatic do_op(input string tag, input logic [2:0] o, input logic [W-1:0] x,
                         input logic [W-1:0] y, input logic [W-1:0] exp_res, input int mode);
        @(negedge clk);
        start = 1'b1;
        op    = o;
        a     = x;
        b     = y;
        @(posedge clk);
        expect_op(tag, exp_res, mode, 3'd0, '0, '0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [2:0]   ro;
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        int           seen;

        reset = 1'b1;
        start = 1'b0;
        op    = '0;
        a     = '0;
        b     = '0;
        repeat (2) @(negedge clk);
        check("reset busy", 64'(busy), 64'(0));
        check("reset done", 64'(done), 64'(0));
        check("reset result", 64'(result), 64'(0));
`ifdef BITWISE_ZERO_FLAG_EN
        check("reset zero", 64'(zero), 64'(0));
`endif
        reset = 1'b0;
        @(negedge clk);

        // Directed vectors
        do_op("not", 3'b000, 32'h0F0F_00FF, 32'h1234_5678, 32'hF0F0_FF00, 0);
        do_op("xor", 3'b011, 32'hFFFF_0000, 32'h0F0F_0F0F, 32'hF0F0_0F0F, 0);
        do_op("xnor", 3'b110, 32'hFFFF_0000, 32'h0F0F_0F0F, 32'h0F0F_F0F0, 0);
        do_op("and", 3'b001, 32'hAAAA_AAAA, 32'h5555_5555, 32'h0000_0000, 0);
        do_op("or", 3'b010, 32'hAAAA_AAAA, 32'h5555_5555, 32'hFFFF_FFFF, 0);
        do_op("nor", 3'b100, 32'hF000_000F, 32'h0000_F0F0, 32'h0FFF_0F00, 0);
        do_op("nand", 3'b101, 32'hFF00_FF00, 32'hF0F0_F0F0, 32'h0FFF_0FFF, 0);

        // Starts while busy are ignored
        do_op("pass ignore", 3'b111, 32'hDEAD_BEEF, 32'h0, 32'hDEAD_BEEF, 1);

        // Back-to-back with start held across the done cycle
        @(negedge clk);
        start = 1'b1;
        op    = 3'b011;
        a     = 32'h1357_9BDF;
        b     = 32'hFFFF_FFFF;
        @(posedge clk);
        expect_op("b2b first", 32'hECA8_6420, 2, 3'b001, 32'hCAFE_F00D, 32'h0FF0_FFFF);
        expect_op("b2b second", 32'h0AF0_F00D, 0, 3'd0, '0, '0);

        // Asynchronous reset during RUN at idx = 2
        @(negedge clk);
        start = 1'b1;
        op    = 3'b111;
        a     = 32'h8765_4321;
        b     = '0;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        check("async rst busy", 64'(busy), 64'(0));
        check("async rst done", 64'(done), 64'(0));
        check("async rst result", 64'(result), 64'(0));
        @(negedge clk);
        reset = 1'b0;
        seen  = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (done === 1'b1 || busy === 1'b1) seen++;
        end
        check("no done after rst", 64'(seen), 64'(0));
        do_op("after rst", 3'b000, 32'h0000_FFFF, 32'h0, 32'hFFFF_0000, 0);

        // Randomized operations
        for (int i = 0; i < 24; i++) begin
            ro = 3'($urandom);
            ra = $urandom;
            rb = $urandom;
            if (i % 6 == 5) rb = ~ra;
            do_op("rand", ro, ra, rb, ref_op(ro, ra, rb), 0);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
